panel_switch_reader: RTL and testbench

//  Reads front-panel switches through a daisy chain of 74HC165 PISO shift registers.
//  It is the input-side counterpart of the 74HC595 activity-LED writer.

---
 rtl/panel_switch_reader_if.sv | 22 ++
 rtl/panel_switch_reader.sv | 174 +++++++++++++++++
 tb/tb_panel_switch_reader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/panel_switch_reader_if.sv
// Signal bundle between the panel switch reader and the 74HC165 chain / consumers.
interface panel_switch_reader_if #(
    parameter int unsigned BITS = 16
);
    logic            sr_sck;
    logic            sr_ld_n;
    logic            sr_qh;
    logic [BITS-1:0] state;
    logic [BITS-1:0] changed;
    logic            valid;
    logic            busy;

    // master: the reader block; slave: the shift chain and downstream routing
    modport master (
        output sr_sck, sr_ld_n, state, changed, valid, busy,
        input  sr_qh
    );
    modport slave (
        input  sr_sck, sr_ld_n, state, changed, valid, busy,
        output sr_qh
    );
endinterface

// File: rtl/panel_switch_reader.sv
// Periodically scans a 74HC165 daisy chain and publishes the parallel switch state,
// a per-bit change mask and a one-cycle valid strobe per completed scan.
module panel_switch_reader #(
    parameter int unsigned BITS    = 16,
    parameter int unsigned CLOCK   = 12_000_000,
    parameter int unsigned SCK_HZ  = 1_000_000,
    parameter int unsigned SCAN_HZ = 1_000,
    parameter bit          INVERT  = 1'b1
) (
    input logic                   clk,
    input logic                   rst_n,
    panel_switch_reader_if.master bus
);

    localparam int unsigned DIV_RAW = CLOCK / (2 * SCK_HZ);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned PERIOD  = CLOCK / SCAN_HZ;
    localparam int unsigned TW      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned CW      = $clog2(2 * DIV);
    localparam int unsigned BW      = $clog2(BITS + 1);

    localparam logic [TW-1:0] TIMER_END = TW'(PERIOD - 1);
    localparam logic [CW-1:0] LOAD_END  = CW'(2 * DIV - 1);
    localparam logic [CW-1:0] PHASE_END = CW'(DIV - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSettle,
        StLow,
        StHigh,
        StDone
    } fsm_e;

    fsm_e            fsm_q, fsm_d;
    logic [TW-1:0]   timer_q;
    logic            pending_q;
    logic            wrap;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bits_q, bits_d;
    logic [BITS-1:0] sh_q, sh_d;

    logic            ld_n_q, ld_n_d;
    logic            sck_q, sck_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [BITS-1:0] state_q, changed_q;
    logic [BITS-1:0] new_state;
    logic            publish;

    assign wrap = (timer_q == TIMER_END);

    // Free-running scan timer; a wrap requests one scan, at most one request is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            timer_q <= wrap ? '0 : timer_q + TW'(1);
            if (wrap) begin
                pending_q <= 1'b1;
            end else if (fsm_q == StIdle) begin
                pending_q <= 1'b0;
            end
        end
    end

    // FSM state register together with phase counter, bit counter and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= StIdle;
            cnt_q  <= '0;
            bits_q <= '0;
            sh_q   <= '0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            bits_q <= bits_d;
            sh_q   <= sh_d;
        end
    end

    // Next state: each phase runs a fixed number of cycles, LOW ends with a sample of QH.
    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q + CW'(1);
        bits_d = bits_q;
        sh_d   = sh_q;
        unique case (fsm_q)
            StIdle: begin
                cnt_d = '0;
                if (pending_q) begin
                    fsm_d = StLoad;
                end
            end
            StLoad: begin
                bits_d = '0;
                if (cnt_q == LOAD_END) begin
                    fsm_d = StSettle;
                    cnt_d = '0;
                end
            end
            StSettle: begin
                if (cnt_q == PHASE_END) begin
                    fsm_d = StLow;
                    cnt_d = '0;
                end
            end
            StLow: begin
                if (cnt_q == PHASE_END) begin
                    // Shift form keeps BITS == 1 legal.
                    sh_d   = (sh_q << 1) | BITS'(bus.sr_qh);
                    bits_d = bits_q + BW'(1);
                    cnt_d  = '0;
                    fsm_d  = (bits_q == LAST_BIT) ? StDone : StHigh;
                end
            end
            StHigh: begin
                if (cnt_q == PHASE_END) begin
                    fsm_d = StLow;
                    cnt_d = '0;
                end
            end
            StDone: begin
                fsm_d = StIdle;
                cnt_d = '0;
            end
            default: begin
                fsm_d = StIdle;
                cnt_d = '0;
            end
        endcase
    end

    // Output decode from the next state so the pins come straight from flops.
    always_comb begin
        ld_n_d    = (fsm_d != StLoad);
        sck_d     = (fsm_d == StHigh);
        busy_d    = (fsm_d != StIdle);
        valid_d   = (fsm_d == StDone);
        publish   = valid_d && (fsm_q != StDone);
        new_state = sh_d ^ {BITS{INVERT}};
    end

    // Registered outputs; result is published on entry to DONE, alongside valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_n_q    <= 1'b1;
            sck_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            state_q   <= '0;
            changed_q <= '0;
        end else begin
            ld_n_q  <= ld_n_d;
            sck_q   <= sck_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            if (publish) begin
                state_q   <= new_state;
                changed_q <= new_state ^ state_q;
            end
        end
    end

    assign bus.sr_ld_n = ld_n_q;
    assign bus.sr_sck  = sck_q;
    assign bus.busy    = busy_q;
    assign bus.valid   = valid_q;
    assign bus.state   = state_q;
    assign bus.changed = changed_q;

endmodule

// File: tb/tb_panel_switch_reader.sv
// Bench for panel_switch_reader: two instances (INVERT=0 / INVERT=1) each driving a
// behavioural 74HC165 chain model.
`timescale 1ns/1ps
module tb_panel_switch_reader;

    localparam int unsigned BITS    = 16;
    localparam int          PERIOD  = 1000;
    localparam int          LD_LOW  = 12;
    localparam int          RISES   = BITS - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    panel_switch_reader_if #(.BITS(BITS)) if0 ();
    panel_switch_reader_if #(.BITS(BITS)) if1 ();

    panel_switch_reader #(
        .BITS(BITS), .CLOCK(12_000_000), .SCK_HZ(1_000_000), .SCAN_HZ(12_000), .INVERT(1'b0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );

    panel_switch_reader #(
        .BITS(BITS), .CLOCK(12_000_000), .SCK_HZ(1_000_000), .SCAN_HZ(12_000), .INVERT(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    // 74HC165 chain: parallel load while SH/LD_n low, shift toward QH on CLK rise.
    logic [BITS-1:0] pins [2];
    logic [BITS-1:0] chain0, chain1;
    always @(posedge if0.sr_sck or negedge if0.sr_ld_n)
        chain0 <= (!if0.sr_ld_n) ? pins[0] : (chain0 << 1);
    always @(posedge if1.sr_sck or negedge if1.sr_ld_n)
        chain1 <= (!if1.sr_ld_n) ? pins[1] : (chain1 << 1);
    assign if0.sr_qh = chain0[BITS-1];
    assign if1.sr_qh = chain1[BITS-1];

    logic            vld_w  [2];
    logic            ld_w   [2];
    logic            sck_w  [2];
    logic            busy_w [2];
    logic [BITS-1:0] st_w   [2];
    logic [BITS-1:0] ch_w   [2];
    assign vld_w[0] = if0.valid;    assign vld_w[1] = if1.valid;
    assign ld_w[0]  = if0.sr_ld_n;  assign ld_w[1]  = if1.sr_ld_n;
    assign sck_w[0] = if0.sr_sck;   assign sck_w[1] = if1.sr_sck;
    assign busy_w[0] = if0.busy;    assign busy_w[1] = if1.busy;
    assign st_w[0]  = if0.state;    assign st_w[1]  = if1.state;
    assign ch_w[0]  = if0.changed;  assign ch_w[1]  = if1.changed;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ld_low [2], sck_rise [2], vcnt [2], ld_fall [2], last_v [2];
    logic ld_prev [2], sck_prev [2];
    bit overlap = 1'b0;

    always @(posedge clk) cyc++;

    // Pin activity monitor, sampled away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!ld_w[d]) ld_low[d]++;
            if (ld_prev[d] && !ld_w[d]) ld_fall[d] = cyc;
            if (sck_w[d] && !sck_prev[d]) sck_rise[d]++;
            if (vld_w[d]) vcnt[d]++;
            if (!ld_w[d] && sck_w[d]) overlap = 1'b1;
            ld_prev[d]  = ld_w[d];
            sck_prev[d] = sck_w[d];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present pins for the next scan of instance d, wait for its valid and check it.
    task automatic run_scan(input int d, input logic [BITS-1:0] p, input logic [BITS-1:0] es,
                            input logic [BITS-1:0] ec, input bit sp, input string name);
        bit found;
        found       = 1'b0;
        pins[d]     = p;
        ld_low[d]   = 0;
        sck_rise[d] = 0;
        vcnt[d]     = 0;
        for (int i = 0; i < 2500 && !found; i++) begin
            @(negedge clk);
            #1;
            if (vld_w[d]) found = 1'b1;
        end
        if (!found) begin
            chk({name, " valid timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({name, " state"}, 32'(st_w[d]), 32'(es));
        chk({name, " changed"}, 32'(ch_w[d]), 32'(ec));
        chk({name, " ld_n low cycles"}, ld_low[d], LD_LOW);
        chk({name, " sck rises"}, sck_rise[d], RISES);
        if (sp) chk({name, " scan spacing"}, cyc - last_v[d], PERIOD);
        last_v[d] = cyc;
        repeat (2) @(negedge clk);
        #1;
        chk({name, " valid pulses"}, vcnt[d], 1);
        chk({name, " busy after scan"}, 32'(busy_w[d]), 32'd0);
    endtask

    typedef struct {
        int              d;
        logic [BITS-1:0] p;
        logic [BITS-1:0] es;
        logic [BITS-1:0] ec;
        bit              sp;
    } vec_t;

    vec_t            tbl [5];
    logic [BITS-1:0] inv_mask [2];
    logic [BITS-1:0] model_prev [2];
    logic [BITS-1:0] p, es, ec;
    int              rel;
    bit              found;

    initial begin
        tbl[0] = '{0, 16'hA5C3, 16'hA5C3, 16'hA5C3, 1'b0};
        tbl[1] = '{0, 16'hA5C3, 16'hA5C3, 16'h0000, 1'b1};
        tbl[2] = '{0, 16'hA5C2, 16'hA5C2, 16'h0001, 1'b1};
        tbl[3] = '{1, 16'hFFFF, 16'h0000, 16'h0000, 1'b0};
        tbl[4] = '{1, 16'h7FFF, 16'h8000, 16'h8000, 1'b1};
        inv_mask[0] = '0;
        inv_mask[1] = '1;

        for (int d = 0; d < 2; d++) begin
            ld_low[d] = 0; sck_rise[d] = 0; vcnt[d] = 0; ld_fall[d] = 0; last_v[d] = 0;
            ld_prev[d] = 1'b1; sck_prev[d] = 1'b0;
        end
        pins[0] = 16'hA5C3;
        pins[1] = 16'hFFFF;
        rst_n   = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset sr_sck", 32'(sck_w[d]), 32'd0);
            chk("reset sr_ld_n", 32'(ld_w[d]), 32'd1);
            chk("reset state", 32'(st_w[d]), 32'd0);
            chk("reset changed", 32'(ch_w[d]), 32'd0);
            chk("reset valid", 32'(vld_w[d]), 32'd0);
            chk("reset busy", 32'(busy_w[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_scan(tbl[i].d, tbl[i].p, tbl[i].es, tbl[i].ec, tbl[i].sp, $sformatf("vec%0d", i));
        model_prev[0] = 16'hA5C2;
        model_prev[1] = 16'h8000;

        // Random pins against the model; occasional repeats exercise an all-zero change mask.
        for (int i = 0; i < 16; i++) begin
            int d;
            d  = i % 2;
            p  = ($urandom_range(0, 3) == 0) ? pins[d] : BITS'($urandom);
            es = p ^ inv_mask[d];
            ec = es ^ model_prev[d];
            run_scan(d, p, es, ec, 1'b0, $sformatf("rand%0d", i));
            model_prev[d] = es;
        end

        // Abort a scan with reset during the shift phase.
        found = 1'b0;
        for (int i = 0; i < 2500 && !found; i++) begin
            @(negedge clk);
            if (busy_w[0]) found = 1'b1;
        end
        chk("busy seen before abort", 32'(found), 32'd1);
        repeat (40) @(negedge clk);
        rst_n   = 1'b0;
        vcnt[0] = 0;
        #1;
        chk("abort sr_sck", 32'(if0.sr_sck), 32'd0);
        chk("abort sr_ld_n", 32'(if0.sr_ld_n), 32'd1);
        chk("abort busy", 32'(if0.busy), 32'd0);
        chk("abort state", 32'(if0.state), 32'd0);
        chk("abort changed", 32'(if0.changed), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("no valid in reset", vcnt[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        run_scan(0, 16'h3C5A, 16'h3C5A, 16'h3C5A, 1'b0, "post-reset");
        // Timer restarts at 0: wrap request after PERIOD edges, load one edge later.
        chk("post-reset first load", ld_fall[0] - rel, PERIOD + 1);

        chk("ld_n/sck never both active", 32'(overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
